// File: rtl/conv_output_streamer.sv
// conv_output_streamer: snapshots the flat conv feature-map bus on start, then
// streams it one word per transfer over valid/ready in channel, row, column
// order, tagging each word with its (channel, row, col) coordinates.
module conv_output_streamer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K          = 6,
    parameter int unsigned OH         = 28,
    parameter int unsigned OW         = 28,
    localparam int unsigned N_WORDS   = K * OH * OW,
    localparam int unsigned BUS_W     = N_WORDS * DATA_WIDTH,
    localparam int unsigned CH_W      = (K  > 1) ? $clog2(K)  : 1,
    localparam int unsigned ROW_W     = (OH > 1) ? $clog2(OH) : 1,
    localparam int unsigned COL_W     = (OW > 1) ? $clog2(OW) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [0:BUS_W-1]      featureMaps,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  outLast,
    output logic [CH_W-1:0]       outChannel,
    output logic [ROW_W-1:0]      outRow,
    output logic [COL_W-1:0]      outCol,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    capture;

    logic [DATA_WIDTH-1:0]   fm_words [N_WORDS];
    logic [DATA_WIDTH-1:0]   snap_q   [N_WORDS];

    logic                    col_end, row_end;
    logic [CH_W-1:0]         nxt_ch;
    logic [ROW_W-1:0]        nxt_row;
    logic [COL_W-1:0]        nxt_col;
    logic [IDX_W-1:0]        nxt_idx;
    logic                    nxt_last;

    // Split the flat bus into words; word w sits at bits [w*DATA_WIDTH +: DATA_WIDTH].
    for (genvar w = 0; w < int'(N_WORDS); w++) begin : g_unpack
        assign fm_words[w] = featureMaps[w*DATA_WIDTH +: DATA_WIDTH];
    end

    // Snapshot register; contents are don't-care until the first capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            snap_q <= fm_words;
        end
    end

    // Coordinate successor of the word currently presented.
    always_comb begin
        col_end  = (col_q == COL_W'(OW - 1));
        row_end  = (row_q == ROW_W'(OH - 1));
        nxt_col  = col_end ? '0 : COL_W'(col_q + COL_W'(1));
        nxt_row  = col_end ? (row_end ? '0 : ROW_W'(row_q + ROW_W'(1))) : row_q;
        nxt_ch   = (col_end && row_end) ? CH_W'(ch_q + CH_W'(1)) : ch_q;
        nxt_idx  = IDX_W'(idx_q + IDX_W'(1));
        nxt_last = (nxt_ch == CH_W'(K - 1)) && (nxt_row == ROW_W'(OH - 1)) &&
                   (nxt_col == COL_W'(OW - 1));
    end

    // Next-state and registered-output logic for the IDLE/STREAM controller.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ch_d    = ch_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        capture = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                    data_d  = fm_words[0];
                    valid_d = 1'b1;
                    last_d  = (N_WORDS == 1);
                    busy_d  = 1'b1;
                    ch_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                if (valid_q && outReady) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = snap_q[nxt_idx];
                        last_d  = nxt_last;
                        ch_d    = nxt_ch;
                        row_d   = nxt_row;
                        col_d   = nxt_col;
                        idx_d   = nxt_idx;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ch_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
        end
    end

    assign outData    = data_q;
    assign outValid   = valid_q;
    assign outLast    = last_q;
    assign outChannel = ch_q;
    assign outRow     = row_q;
    assign outCol     = col_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed bench for conv_output_streamer with K=2, OH=2, OW=3, DATA_WIDTH=8.
module tb_conv_output_streamer;

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [0:NW*DW-1]  featureMaps;
    logic [DW-1:0]     outData;
    logic              outValid;
    logic              outReady;
    logic              outLast;
    logic [0:0]        outChannel;
    logic [0:0]        outRow;
    logic [1:0]        outCol;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;

    conv_output_streamer #(
        .DATA_WIDTH(DW), .K(2), .OH(2), .OW(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .featureMaps(featureMaps),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .outLast(outLast), .outChannel(outChannel), .outRow(outRow),
        .outCol(outCol), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_fm(input int base);
        for (int w = 0; w < int'(NW); w++) featureMaps[w*DW +: DW] = DW'(w + base);
    endtask

    // Check the word presented at stream position w against pattern (w + base).
    task automatic chk_word(input string tag, input int w, input int base);
        chk({tag, ".valid"}, 32'(outValid), 32'd1);
        chk({tag, ".data"},  32'(outData), 32'(w + base));
        chk({tag, ".ch"},    32'(outChannel), 32'(w / 6));
        chk({tag, ".row"},   32'(outRow), 32'((w / 3) % 2));
        chk({tag, ".col"},   32'(outCol), 32'(w % 3));
        chk({tag, ".last"},  32'(outLast), 32'(w == 11));
        chk({tag, ".busy"},  32'(busy), 32'd1);
        chk({tag, ".done"},  32'(done), 32'd0);
    endtask

    task automatic chk_done_cycle(input string tag);
        chk({tag, ".valid"}, 32'(outValid), 32'd0);
        chk({tag, ".last"},  32'(outLast), 32'd0);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".done"},  32'(done), 32'd1);
    endtask

    initial begin
        int exp_w;
        reset = 1'b1; start = 1'b0; outReady = 1'b0;
        load_fm(1);
        step(); step();
        reset = 1'b0;
        step();
        chk("rst.valid", 32'(outValid), 32'd0);
        chk("rst.data",  32'(outData), 32'd0);
        chk("rst.last",  32'(outLast), 32'd0);
        chk("rst.coord", {29'd0, outChannel, outRow, outCol}, 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.done",  32'(done), 32'd0);

        // Full throughput: start at cycle 0, words on cycles 1..12, done on 13.
        outReady = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk_word("full", i, 1);
            step();
        end
        chk_done_cycle("full.end");
        step();
        chk("full.done_once", 32'(done), 32'd0);

        // Backpressure: stall 4 cycles while word 0x04 is presented.
        start = 1'b1;
        step(); start = 1'b0;
        exp_w = 0;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            outReady = (cyc < 4) || (cyc > 7);
            chk("bp.done_time", 32'(done), 32'(cyc == 17));
            if (cyc <= 16) chk_word("bp", exp_w, 1);
            if (cyc >= 4 && cyc <= 7) chk("bp.hold", 32'(outData), 32'h04);
            if (cyc <= 16 && outReady) exp_w++;
            step();
        end
        chk("bp.count", 32'(exp_w), 32'd12);
        outReady = 1'b1;

        // Snapshot isolation, start ignored mid-stream, start accepted in done cycle.
        start = 1'b1;
        step(); start = 1'b0;
        load_fm(32'hFF);
        for (int i = 0; i < 12; i++) begin
            chk_word("snap", i, 1);
            start = (i == 6);
            step();
            start = 1'b0;
        end
        chk_done_cycle("snap.end");
        load_fm(32'h21);
        start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk_word("restart", i, 32'h21);
            step();
        end
        chk_done_cycle("restart.end");
        step();

        // Reset asserted while word 0x05 is transferring.
        load_fm(1);
        start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid.pre", 32'(outData), 32'h05);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("mid.valid", 32'(outValid), 32'd0);
        chk("mid.busy",  32'(busy), 32'd0);
        chk("mid.done",  32'(done), 32'd0);
        chk("mid.data",  32'(outData), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid.no_done", 32'(done | outValid), 32'd0);
        end
        start = 1'b1;
        step(); start = 1'b0;
        chk_word("mid.restart", 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
